// File: rtl/mul_stall_ctrl.sv
// EX-stage multiply sequencer: launches the iterative multiplier, stalls the front end
// for MUL_LAT+1 cycles, then steers the multiplier result into EX/MEM for one cycle.
module mul_stall_ctrl #(
  parameter int unsigned MUL_LAT     = 4,
  parameter logic [2:0]  MUL_OP      = 3'b011,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [2:0]             ALUCtrl_i,
  input  logic                   flush_i,
  output logic                   mul_start_o,
  output logic                   mul_abort_o,
  output logic                   stall_o,
  output logic                   result_sel_o,
  output logic                   result_valid_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic is_mul;
  logic start, abort, stall, sel, rvalid;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  assign is_mul = valid_i & (ALUCtrl_i == MUL_OP) & ~flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    abort   = 1'b0;
    stall   = 1'b0;
    sel     = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        start = is_mul;
        stall = is_mul;
        if (is_mul) begin
          state_d = BUSY;
          cnt_d   = 4'(MUL_LAT - 1);
        end
      end
      BUSY: begin
        if (flush_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = DONE;
        end
      end
      DONE: begin
        // The finishing mul is still in EX here; returning to IDLE without
        // looking at the decode keeps it from relaunching itself.
        abort   = flush_i;
        sel     = ~flush_i;
        rvalid  = ~flush_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Decoded outputs are masked so reset silences them without waiting for an edge.
  assign mul_start_o    = start  & ~rst_i;
  assign mul_abort_o    = abort  & ~rst_i;
  assign stall_o        = stall  & ~rst_i;
  assign result_sel_o   = sel    & ~rst_i;
  assign result_valid_o = rvalid & ~rst_i;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_mul_stall_ctrl.sv
// Bench for mul_stall_ctrl: two instances (MUL_LAT=4/32-bit counter, MUL_LAT=1/4-bit counter)
// share stimulus and are checked every cycle against a timeline model plus literal expectations.
module tb_mul_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [2:0] op = 3'b000;
  logic flush = 1'b0;

  logic start_w[2], abort_w[2], stall_w[2], sel_w[2], rvalid_w[2];
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit rst_pulsed = 1'b0;

  always #5 clk = ~clk;

  mul_stall_ctrl #(.MUL_LAT(4), .MUL_OP(3'b011), .STALL_CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(op), .flush_i(flush),
    .mul_start_o(start_w[0]), .mul_abort_o(abort_w[0]), .stall_o(stall_w[0]),
    .result_sel_o(sel_w[0]), .result_valid_o(rvalid_w[0]), .stall_cnt_o(cnt_a)
  );

  mul_stall_ctrl #(.MUL_LAT(1), .MUL_OP(3'b011), .STALL_CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUCtrl_i(op), .flush_i(flush),
    .mul_start_o(start_w[1]), .mul_abort_o(abort_w[1]), .stall_o(stall_w[1]),
    .result_sel_o(sel_w[1]), .result_valid_o(rvalid_w[1]), .stall_cnt_o(cnt_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a mul accepted at age 0 stalls through age L, completes at age L+1.
  int unsigned      lat[2]  = '{4, 1};
  longint unsigned  cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  bit               act[2];
  int               age[2];
  longint unsigned  mcnt[2];

  initial begin
    bit is_mul, e_start, e_abort, e_stall, e_sel, e_val;
    logic [63:0] cnt_v;
    forever begin
      @(negedge clk);
      if (rst || rst_pulsed) begin
        for (int i = 0; i < 2; i++) begin
          act[i] = 1'b0; age[i] = 0; mcnt[i] = 0;
        end
        rst_pulsed = 1'b0;
      end
      is_mul = valid && (op == 3'b011) && !flush;
      for (int i = 0; i < 2; i++) begin
        e_start = 0; e_abort = 0; e_stall = 0; e_sel = 0; e_val = 0;
        cnt_v = (i == 0) ? 64'(cnt_a) : 64'(cnt_b);
        if (!rst) begin
          if (!act[i]) begin
            e_start = is_mul;
            e_stall = is_mul;
          end else if (age[i] <= int'(lat[i])) begin
            e_abort = flush;
            e_stall = !flush;
          end else begin
            e_abort = flush;
            e_sel   = !flush;
            e_val   = !flush;
          end
        end
        chk($sformatf("start[%0d]", i),  64'(start_w[i]),  64'(e_start));
        chk($sformatf("abort[%0d]", i),  64'(abort_w[i]),  64'(e_abort));
        chk($sformatf("stall[%0d]", i),  64'(stall_w[i]),  64'(e_stall));
        chk($sformatf("sel[%0d]", i),    64'(sel_w[i]),    64'(e_sel));
        chk($sformatf("rvalid[%0d]", i), 64'(rvalid_w[i]), 64'(e_val));
        chk($sformatf("stall_cnt[%0d]", i), cnt_v, 64'(mcnt[i]));
        if (!rst) begin
          if (e_stall && mcnt[i] < cmax[i]) mcnt[i]++;
          if (!act[i]) begin
            if (is_mul) begin act[i] = 1'b1; age[i] = 1; end
          end else if (age[i] <= int'(lat[i]) && !flush) begin
            age[i]++;
          end else begin
            act[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [2:0] o, input bit f);
    valid = v; op = o; flush = f;
  endtask

  // Asynchronous pulse placed between edges; the model is told through rst_pulsed.
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    rst_pulsed = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_stall", 64'(stall_w[0]), 64'd0);
    chk("rst_start", 64'(start_w[0]), 64'd0);
    chk("rst_cnt",   64'(cnt_a),      64'd0);
    cyc(); cyc();
    rst = 1'b0;

    // Single mul, MUL_LAT=4
    for (int t = 0; t <= 6; t++) begin
      set_in(t <= 4, 3'b011, 1'b0);
      @(negedge clk);
      if (t <= 4) chk("t1_stall", 64'(stall_w[0]), 64'd1);
      chk("t1_start", 64'(start_w[0]), 64'(t == 0));
      chk("t1_rvalid", 64'(rvalid_w[0]), 64'(t == 5));
      if (t == 6) chk("t1_cnt", 64'(cnt_a), 64'd5);
      cyc();
    end

    // Non-mul ops pass through
    pulse_rst();
    for (int t = 0; t < 6; t++) begin
      set_in(1'b1, (t % 2 == 0) ? 3'b010 : 3'b111, 1'b0);
      @(negedge clk);
      chk("t2_stall", 64'(stall_w[0]), 64'd0);
      chk("t2_start", 64'(start_w[0]), 64'd0);
      chk("t2_rvalid", 64'(rvalid_w[0]), 64'd0);
      cyc();
    end

    // Back-to-back muls
    pulse_rst();
    for (int t = 0; t <= 12; t++) begin
      set_in(t <= 10, 3'b011, 1'b0);
      @(negedge clk);
      chk("t3_start", 64'(start_w[0]), 64'(t == 0 || t == 6));
      chk("t3_rvalid", 64'(rvalid_w[0]), 64'(t == 5 || t == 11));
      if (t == 12) chk("t3_cnt", 64'(cnt_a), 64'd10);
      cyc();
    end

    // Flush during BUSY
    pulse_rst();
    for (int t = 0; t <= 8; t++) begin
      set_in(t <= 2, 3'b011, t == 2);
      @(negedge clk);
      if (t == 2) begin
        chk("t4_stall", 64'(stall_w[0]), 64'd0);
        chk("t4_abort", 64'(abort_w[0]), 64'd1);
      end
      if (t == 3) chk("t4_idle_stall", 64'(stall_w[0]), 64'd0);
      chk("t4_rvalid", 64'(rvalid_w[0]), 64'd0);
      cyc();
    end

    // Async reset mid-BUSY, then clean restart of the held mul
    pulse_rst();
    for (int t = 0; t <= 8; t++) begin
      set_in(t <= 7, 3'b011, 1'b0);
      if (t == 3) begin
        #1 rst = 1'b1;
        #1;
        chk("t5_stall_in_rst", 64'(stall_w[0]), 64'd0);
        chk("t5_cnt_in_rst", 64'(cnt_a), 64'd0);
        chk("t5_start_in_rst", 64'(start_w[0]), 64'd0);
        rst = 1'b0;
        rst_pulsed = 1'b1;
      end
      @(negedge clk);
      if (t == 3) chk("t5_restart", 64'(start_w[0]), 64'd1);
      if (t == 8) chk("t5_rvalid", 64'(rvalid_w[0]), 64'd1);
      cyc();
    end

    // MUL_LAT=1 timing, then saturation of the 4-bit counter
    pulse_rst();
    for (int t = 0; t <= 2; t++) begin
      set_in(t == 0, 3'b011, 1'b0);
      @(negedge clk);
      chk("t6_stall_b", 64'(stall_w[1]), 64'(t <= 1));
      chk("t6_rvalid_b", 64'(rvalid_w[1]), 64'(t == 2));
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < 3; t++) begin
        set_in(t == 0, 3'b011, 1'b0);
        cyc();
      end
    end
    @(negedge clk);
    chk("t6_sat_b", 64'(cnt_b), 64'd15);
    cyc();

    // Randomized traffic
    pulse_rst();
    for (int n = 0; n < 600; n++) begin
      logic [2:0] ops[8];
      ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b110, 3'b111};
      set_in($urandom_range(0, 3) != 0, ops[$urandom_range(0, 7)], $urandom_range(0, 7) == 0);
      cyc();
    end
    set_in(1'b0, 3'b000, 1'b0);
    repeat (8) cyc();
    @(negedge clk);
    chk("end_sat_b", 64'(cnt_b), 64'd15);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
